sd_spi_responder: RTL and testbench
===================================

Name: sd_spi_responder

Overview:
- SPI-mode SD-card responder. It is the card-side counterpart of the SDC_top SPI initiator.
- It receives 48-bit command frames on MOSI and answers on MISO with R1/R3/R7 responses.
- It tracks the card init sequence: CMD0, CMD8, CMD55+ACMD41, CMD58.
- It is used as a synthesizable card model in benches and as an on-FPGA loopback target.

Parameters:
- NCR_BYTES, 1, number of 0xFF bytes driven between the frame end bit and the first response bit (1..8).
- INIT_RETRIES, 2, number of ACMD41 commands answered 0x01 before one is answered 0x00.
- OCR, 32'hC0FF8000, value returned after the R1 byte of CMD58.

Ports:
- i_clk  in  1  system clock; SCLK must be at most i_clk/8.
- i_rst  in  1  asynchronous active-high reset.
- i_sclk  in  1  SPI clock from the initiator.
- i_cs  in  1  chip select, active low.
- i_mosi  in  1  serial data from the initiator.
- o_miso  out  1  serial data to the initiator.
- o_cmd_valid  out  1  one-cycle pulse per accepted frame.
- o_cmd_idx  out  6  command index of the last accepted frame.
- o_cmd_arg  out  32  argument of the last accepted frame.
- o_frame_err  out  1  one-cycle pulse when a frame's end bit is 0.
- o_idle  out  1  card idle flag; equals the R1 bit 0.

Behaviour:
- Input sampling:
  - i_sclk, i_cs and i_mosi each pass through a 2-flop synchronizer.
  - Rising and falling SCLK edges are detected on the synchronized signal.
  - SPI mode 0, MSB first.
  - MOSI is sampled on rising edges. o_miso changes only on falling edges or on abort/reset.
- Reset (async):
  - o_miso=1, o_cmd_valid=0, o_cmd_idx=0, o_cmd_arg=0, o_frame_err=0.
  - o_idle=1, app flag=0, retry counter=0, state=HUNT.
- CS high (synchronized), in any state:
  - Next i_clk: state=HUNT, bit counters cleared, o_miso=1.
  - o_idle, app flag and retry counter are retained.
  - Rising edges are ignored while CS is high.
- HUNT:
  - A 2-bit window watches rising-edge samples.
  - On "0" (start bit) followed by "1" (transmission bit), go to RECV with bit count=2.
- RECV: shift 46 further bits; fields are idx[5:0], arg[31:0], crc[6:0], end bit.
  - End bit 0: pulse o_frame_err, go to HUNT, send no response.
  - End bit 1: go to WAIT. In the same cycle, pulse o_cmd_valid and update o_cmd_idx and o_cmd_arg.
  - The CRC is not checked.
- Response decode (at frame end; R1 = {1'b0, 4'b0, illegal, 1'b0, idle} for the pre-update state):
  - CMD0: R1=0x01; set o_idle=1; clear the retry counter.
  - CMD8: R1 followed by 32-bit echo of the argument (R7, 40 bits).
  - CMD55: R1; set the app flag.
  - CMD41 with app flag set:
    - If retry counter < INIT_RETRIES: R1=0x01 and retry+1.
    - Otherwise: R1=0x00 and o_idle=0. o_idle falls at frame end, so this R1 already reads 0x00.
  - CMD58: R1 followed by OCR (40 bits).
  - Any other index, including CMD41 without the app flag: R1 with the illegal bit set (0x05 idle, 0x04 ready).
  - The app flag is cleared by every command other than CMD55.
- WAIT:
  - Output 1s for NCR_BYTES*8 falling edges.
  - The count starts at the first falling edge after the end-bit rising edge.
- SEND:
  - On each falling edge, drive the next response bit MSB-first from a 40-bit shift register.
  - Length is 8 or 40 bits.
  - After the last bit has been held for one falling edge, drive o_miso=1 and go to HUNT.
  - MOSI is ignored during WAIT and SEND.
- Simultaneous events:
  - CS-high abort wins over any SCLK edge in the same cycle.
  - Reset wins over everything.

Test Plan:
- CMD0 frame 40 00 00 00 00 95:
  - one 0xFF byte, then MISO byte 0x01.
  - o_cmd_valid pulses once with idx=0, arg=0.
  - o_idle=1.
- CMD8 frame 48 00 00 01 AA 87:
  - after 0xFF, MISO bytes 01 00 00 01 AA, then 0xFF.
- CMD55 followed by ACMD41 (arg 40000000), pair repeated three times:
  - ACMD41 responses 0x01, 0x01, 0x00.
  - o_idle falls at the third ACMD41 frame end.
  - Every CMD55 answers with the current R1.
- After init, CMD58: MISO bytes 00 C0 FF 80 00. Then CMD17: 0x04. Then ACMD41 without CMD55: 0x04.
- Frame with end bit 0 (CMD0 with CRC byte 0x94): o_frame_err pulses once, no o_cmd_valid, MISO stays 1 for the next 16 clocks.
- Abort and reset:
  - CS raised after 20 bits of CMD0, then a full CMD0 sent: only the second frame produces o_cmd_valid, answered 0x01.
  - i_rst pulsed mid-response: o_miso=1 immediately and o_idle=1.

Source files
------------

// File: rtl/sd_spi_responder.sv
// SPI-mode SD-card responder: decodes 48-bit command frames on MOSI and answers on MISO
// with R1/R3/R7 responses while tracking the CMD0/CMD8/CMD55+ACMD41/CMD58 init sequence.
// Latency: NCR_BYTES*8 SCLK falling edges of 0xFF after the frame end bit, then the response.
// Backpressure: none; the initiator owns SCLK, and CS high aborts any frame or response.
//
// Ports:
//   i_clk, i_rst           system clock (>= 8x SCLK), async active-high reset
//   i_sclk, i_cs, i_mosi   SPI inputs from the initiator (asynchronous, synchronized here)
//   o_miso                 SPI data to the initiator, changes on SCLK falling edges
//   o_cmd_valid            one-cycle pulse per accepted frame (end bit 1)
//   o_cmd_idx, o_cmd_arg   index/argument of the last accepted frame
//   o_frame_err            one-cycle pulse when a frame ends with end bit 0
//   o_idle                 card idle flag (R1 bit 0)
module sd_spi_responder #(
  parameter int          NCR_BYTES    = 1,
  parameter int          INIT_RETRIES = 2,
  parameter logic [31:0] OCR          = 32'hC0FF8000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sclk,
  input  logic        i_cs,
  input  logic        i_mosi,
  output logic        o_miso,
  output logic        o_cmd_valid,
  output logic [5:0]  o_cmd_idx,
  output logic [31:0] o_cmd_arg,
  output logic        o_frame_err,
  output logic        o_idle
);

  localparam int         RW        = $clog2(INIT_RETRIES + 2);
  localparam logic [6:0] WAIT_LAST = 7'(NCR_BYTES * 8 - 1);
  localparam logic [6:0] FRAME_END = 7'd47;  // bit index of the end bit

  typedef enum logic [1:0] {HUNT, RECV, WAIT, SEND} state_e;

  // Input synchronizers; sclk carries a third stage for edge detection.
  logic [2:0] sclk_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b11;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], i_sclk};
      cs_sync_q   <= {cs_sync_q[0], i_cs};
      mosi_sync_q <= {mosi_sync_q[0], i_mosi};
    end
  end

  logic sclk_rise, sclk_fall, cs_hi, mosi_s;
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_hi     = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];

  state_e         state_q, state_d;
  logic           prev_q, prev_d;       // older sample of the 2-bit start window
  logic [44:0]    rx_q, rx_d;           // idx, arg, crc shifted in MSB first
  logic [6:0]     cnt_q, cnt_d;         // bit count in RECV/SEND, fall count in WAIT
  logic [39:0]    tx_q, tx_d;
  logic [6:0]     txlen_q, txlen_d;
  logic           miso_q, miso_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic [5:0]     cmd_idx_q, cmd_idx_d;
  logic [31:0]    cmd_arg_q, cmd_arg_d;
  logic           frame_err_q, frame_err_d;
  logic           idle_q, idle_d;
  logic           app_q, app_d;
  logic [RW-1:0]  retry_q, retry_d;

  // Frame fields as they stand when the end bit arrives.
  logic [5:0]  rx_idx;
  logic [31:0] rx_arg;
  assign rx_idx = rx_q[44:39];
  assign rx_arg = rx_q[38:7];

  logic start_seen, frame_end, wait_done, send_done;
  assign start_seen = (state_q == HUNT) && sclk_rise && !prev_q && mosi_s;
  assign frame_end  = (state_q == RECV) && sclk_rise && (cnt_q == FRAME_END);
  assign wait_done  = (state_q == WAIT) && sclk_fall && (cnt_q == WAIT_LAST);
  assign send_done  = (state_q == SEND) && sclk_fall && (cnt_q == txlen_q);

  // Response decode; R1 reflects the idle flag before this command updates it,
  // except where the command itself defines the R1 value.
  logic          rsp_illegal, rsp_idle, rsp_long;
  logic [31:0]   rsp_word;
  logic          idle_nx, app_nx;
  logic [RW-1:0] retry_nx;
  logic [7:0]    rsp_r1;

  always_comb begin
    rsp_illegal = 1'b0;
    rsp_idle    = idle_q;
    rsp_long    = 1'b0;
    rsp_word    = 32'hFFFF_FFFF;
    idle_nx     = idle_q;
    retry_nx    = retry_q;
    app_nx      = (rx_idx == 6'd55);
    case (rx_idx)
      6'd0: begin
        rsp_idle = 1'b1;
        idle_nx  = 1'b1;
        retry_nx = '0;
      end
      6'd8: begin
        rsp_long = 1'b1;
        rsp_word = rx_arg;
      end
      6'd55: ;
      6'd41: begin
        if (!app_q) begin
          rsp_illegal = 1'b1;
        end else if (retry_q < RW'(INIT_RETRIES)) begin
          rsp_idle = 1'b1;
          retry_nx = retry_q + RW'(1);
        end else begin
          // Init completes here, so this R1 already reports ready.
          rsp_idle = 1'b0;
          idle_nx  = 1'b0;
        end
      end
      6'd58: begin
        rsp_long = 1'b1;
        rsp_word = OCR;
      end
      default: rsp_illegal = 1'b1;
    endcase
    rsp_r1 = {5'b0, rsp_illegal, 1'b0, rsp_idle};
  end

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= HUNT;
    else       state_q <= state_d;
  end

  // FSM: next state; CS high overrides any SCLK edge
  always_comb begin
    state_d = state_q;
    if (cs_hi) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT: if (start_seen) state_d = RECV;
        RECV: if (frame_end)  state_d = mosi_s ? WAIT : HUNT;
        WAIT: if (wait_done)  state_d = SEND;
        SEND: if (send_done)  state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // FSM: outputs and datapath next values
  always_comb begin
    prev_d      = prev_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    txlen_d     = txlen_q;
    miso_d      = miso_q;
    cmd_valid_d = 1'b0;
    cmd_idx_d   = cmd_idx_q;
    cmd_arg_d   = cmd_arg_q;
    frame_err_d = 1'b0;
    idle_d      = idle_q;
    app_d       = app_q;
    retry_d     = retry_q;
    if (cs_hi) begin
      prev_d = 1'b1;
      cnt_d  = '0;
      miso_d = 1'b1;
    end else begin
      case (state_q)
        HUNT: begin
          if (sclk_rise) begin
            prev_d = mosi_s;
            if (start_seen) cnt_d = 7'd2;
          end
        end
        RECV: begin
          if (frame_end) begin
            cnt_d  = '0;
            prev_d = 1'b1;
            if (mosi_s) begin
              cmd_valid_d = 1'b1;
              cmd_idx_d   = rx_idx;
              cmd_arg_d   = rx_arg;
              idle_d      = idle_nx;
              app_d       = app_nx;
              retry_d     = retry_nx;
              tx_d        = {rsp_r1, rsp_word};
              txlen_d     = rsp_long ? 7'd40 : 7'd8;
            end else begin
              frame_err_d = 1'b1;
            end
          end else if (sclk_rise) begin
            rx_d  = {rx_q[43:0], mosi_s};
            cnt_d = cnt_q + 7'd1;
          end
        end
        WAIT: begin
          if (sclk_fall) cnt_d = wait_done ? 7'd0 : cnt_q + 7'd1;
        end
        SEND: begin
          if (sclk_fall) begin
            if (send_done) begin
              // Last bit has been held for a full SCLK period; release the line.
              miso_d = 1'b1;
              cnt_d  = '0;
              prev_d = 1'b1;
            end else begin
              miso_d = tx_q[39];
              tx_d   = {tx_q[38:0], 1'b1};
              cnt_d  = cnt_q + 7'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_q      <= 1'b1;
      rx_q        <= '0;
      cnt_q       <= '0;
      tx_q        <= '1;
      txlen_q     <= 7'd8;
      miso_q      <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_idx_q   <= '0;
      cmd_arg_q   <= '0;
      frame_err_q <= 1'b0;
      idle_q      <= 1'b1;
      app_q       <= 1'b0;
      retry_q     <= '0;
    end else begin
      prev_q      <= prev_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      txlen_q     <= txlen_d;
      miso_q      <= miso_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_idx_q   <= cmd_idx_d;
      cmd_arg_q   <= cmd_arg_d;
      frame_err_q <= frame_err_d;
      idle_q      <= idle_d;
      app_q       <= app_d;
      retry_q     <= retry_d;
    end
  end

  assign o_miso      = miso_q;
  assign o_cmd_valid = cmd_valid_q;
  assign o_cmd_idx   = cmd_idx_q;
  assign o_cmd_arg   = cmd_arg_q;
  assign o_frame_err = frame_err_q;
  assign o_idle      = idle_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: drives SPI frames, compares MISO bytes, command pulses and
// the idle flag against a card-level model plus literal R1 values.
// SCLK period is 10 i_clk periods; all inputs change on i_clk falling edges.
module tb_sd_spi_responder;

  localparam int          NCR   = 1;
  localparam int          RETRY = 2;
  localparam logic [31:0] OCRV  = 32'hC0FF8000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b1;
  logic        miso;
  logic        cmd_valid;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        frame_err;
  logic        idle;

  always #5 clk = ~clk;

  sd_spi_responder #(.NCR_BYTES(NCR), .INIT_RETRIES(RETRY), .OCR(OCRV)) dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs(cs), .i_mosi(mosi),
    .o_miso(miso), .o_cmd_valid(cmd_valid), .o_cmd_idx(cmd_idx), .o_cmd_arg(cmd_arg),
    .o_frame_err(frame_err), .o_idle(idle)
  );

  int tests = 0;
  int fails = 0;
  int ferr_cnt = 0;

  // Card model state
  bit m_idle  = 1'b1;
  bit m_app   = 1'b0;
  int m_retry = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        idle_after;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] exp_bytes[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every accepted-frame pulse must match the next modelled command.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected cmd_valid", 64'(cmd_idx), 64'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cmd_idx", 64'(cmd_idx), 64'(e.idx));
          chk("cmd_arg", 64'(cmd_arg), 64'(e.arg));
          chk("idle at frame end", 64'(idle), 64'(e.idle_after));
        end
      end
      if (frame_err) ferr_cnt++;
    end
  end

  // Model: expected MISO bytes after the frame (Ncr fill, response, one trailing 0xFF).
  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [7:0]  r1;
    logic [31:0] w;
    bit          longr;
    exp_bytes.delete();
    for (int i = 0; i < NCR; i++) exp_bytes.push_back(8'hFF);
    longr = 1'b0;
    w     = 32'h0;
    case (idx)
      6'd0: begin
        m_idle = 1'b1; m_retry = 0; r1 = 8'h01;
      end
      6'd8: begin
        r1 = {7'b0, m_idle}; longr = 1'b1; w = arg;
      end
      6'd55: r1 = {7'b0, m_idle};
      6'd41: begin
        if (!m_app) r1 = {5'b0, 1'b1, 1'b0, m_idle};
        else if (m_retry < RETRY) begin r1 = 8'h01; m_retry++; end
        else begin m_idle = 1'b0; r1 = 8'h00; end
      end
      6'd58: begin
        r1 = {7'b0, m_idle}; longr = 1'b1; w = OCRV;
      end
      default: r1 = {5'b0, 1'b1, 1'b0, m_idle};
    endcase
    m_app = (idx == 6'd55);
    exp_bytes.push_back(r1);
    if (longr) for (int b = 3; b >= 0; b--) exp_bytes.push_back(w[b*8 +: 8]);
    exp_bytes.push_back(8'hFF);
    exp_q.push_back('{idx, arg, m_idle});
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    mosi = b;
    #50;
    r = miso;
    sclk = 1'b1;
    #50;
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) xfer_bit(tx[i], rx[i]);
  endtask

  task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [47:0] f;
    logic [7:0]  rx;
    f = {2'b01, idx, arg, crc};
    for (int b = 5; b >= 0; b--) begin
      xfer(f[b*8 +: 8], rx);
      chk("miso idle during frame", 64'(rx), 64'hFF);
    end
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                         input logic [7:0] r1_lit);
    logic [7:0] rx;
    model_cmd(idx, arg);
    @(negedge clk);
    cs = 1'b0;
    #50;
    send_frame(idx, arg, crc);
    for (int k = 0; k < exp_bytes.size(); k++) begin
      xfer(8'hFF, rx);
      chk($sformatf("CMD%0d rsp byte %0d", idx, k), 64'(rx), 64'(exp_bytes[k]));
      if (k == NCR) chk($sformatf("CMD%0d R1 literal", idx), 64'(rx), 64'(r1_lit));
    end
    mosi = 1'b1;
    cs   = 1'b1;
    #200;
  endtask

  initial begin
    logic [7:0] rx;
    logic       rb;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset miso", 64'(miso), 64'd1);
    chk("reset cmd_valid", 64'(cmd_valid), 64'd0);
    chk("reset cmd_idx", 64'(cmd_idx), 64'd0);
    chk("reset cmd_arg", 64'(cmd_arg), 64'd0);
    chk("reset frame_err", 64'(frame_err), 64'd0);
    chk("reset idle", 64'(idle), 64'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_cmd(6'd0, 32'h0, 8'h95, 8'h01);
    chk("idle after CMD0", 64'(idle), 64'd1);
    run_cmd(6'd8, 32'h000001AA, 8'h87, 8'h01);

    for (int k = 0; k < 3; k++) begin
      run_cmd(6'd55, 32'h0, 8'h65, 8'h01);
      run_cmd(6'd41, 32'h40000000, 8'h77, (k < 2) ? 8'h01 : 8'h00);
    end
    chk("idle after init", 64'(idle), 64'd0);

    run_cmd(6'd58, 32'h0, 8'hFD, 8'h00);
    run_cmd(6'd17, 32'h0, 8'h55, 8'h04);
    run_cmd(6'd41, 32'h40000000, 8'h77, 8'h04);

    // Reset in the middle of a CMD8 response (R1 = 0x00, so MISO is low on its MSB).
    model_cmd(6'd8, 32'h000001AA);
    @(negedge clk);
    cs = 1'b0;
    #50;
    send_frame(6'd8, 32'h000001AA, 8'h87);
    xfer(8'hFF, rx);
    chk("pre-reset Ncr byte", 64'(rx), 64'hFF);
    #100;
    chk("pre-reset R1 msb on miso", 64'(miso), 64'd0);
    rst = 1'b1;
    #1;
    chk("async reset miso", 64'(miso), 64'd1);
    chk("async reset idle", 64'(idle), 64'd1);
    chk("async reset cmd_idx", 64'(cmd_idx), 64'd0);
    cs   = 1'b1;
    mosi = 1'b1;
    #19;
    rst = 1'b0;
    m_idle = 1'b1; m_app = 1'b0; m_retry = 0;
    #100;

    // End bit 0: frame error, no command, no response.
    @(negedge clk);
    cs = 1'b0;
    #50;
    send_frame(6'd0, 32'h0, 8'h94);
    for (int k = 0; k < 2; k++) begin
      xfer(8'hFF, rx);
      chk("miso after bad frame", 64'(rx), 64'hFF);
    end
    cs = 1'b1;
    #200;
    chk("frame_err pulses", 64'(ferr_cnt), 64'd1);

    // Abort after 20 bits of CMD0, then a full CMD0.
    @(negedge clk);
    cs = 1'b0;
    #50;
    xfer(8'h40, rx);
    xfer(8'h00, rx);
    for (int i = 0; i < 4; i++) xfer_bit(1'b0, rb);
    cs   = 1'b1;
    mosi = 1'b1;
    #200;
    run_cmd(6'd0, 32'h0, 8'h95, 8'h01);
    run_cmd(6'd8, 32'h000001AA, 8'h87, 8'h01);

    #500;
    chk("missing cmd_valid", 64'(exp_q.size()), 64'd0);
    chk("frame_err pulses final", 64'(ferr_cnt), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
